paddle_ctrl: RTL and testbench

Parametrised paddle controller for the Pong datapath. It replaces fixed top/mid/bot hit flags with N hit zones and a registered one-cycle hit pulse with zone index. It adds slew-limited movement and a player/AI/hold mode select. It also has a hit-cooldown FSM so a ball overlapping for several frames registers one hit. It sits between the input/AI target source, the ball engine (consumes hit/hit_zone) and the VGA pixel mux (consumes rgb).

---
 rtl/pong_pkg.sv | 26 ++
 rtl/hit_zone_enc.sv | 31 +++
 rtl/paddle_ctrl.sv | 137 +++++++++++++
 tb/tb_paddle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong datapath blocks.
// Signed coordinates carry headroom so ball/paddle arithmetic never wraps.
package pong_pkg;

  typedef logic [9:0] coord_t;
  typedef logic signed [11:0] scoord_t;

  typedef enum logic [1:0] {
    PLAYER = 2'd0,
    AI     = 2'd1,
    HOLD   = 2'd2
  } paddle_mode_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COOL       = 2'd1,
    WAIT_CLEAR = 2'd2
  } hit_state_e;

  function automatic scoord_t clamp_y(input scoord_t v, input scoord_t lo, input scoord_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/hit_zone_enc.sv
// Maps the ball-centre offset within the paddle to one of ZONES equal bands.
// Each threshold is a constant compare; the zone is the highest threshold passed.
module hit_zone_enc
  import pong_pkg::*;
#(
  parameter int HEIGHT = 60,
  parameter int ZONES  = 3,
  parameter int ZW     = $clog2(ZONES)
) (
  input  scoord_t         off,
  output logic [ZW-1:0]   zone
);

  logic [ZONES-1:1] above;

  generate
    for (genvar gi = 1; gi < ZONES; gi++) begin : g_th
      localparam int TH = gi * HEIGHT / ZONES;
      assign above[gi] = (off >= scoord_t'(TH));
    end
  endgenerate

  // Thresholds rise monotonically, so the last set bit is the zone.
  always_comb begin
    zone = '0;
    for (int i = 1; i < ZONES; i++) begin
      if (above[i]) zone = ZW'(i);
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: slew-limited motion from player/AI target, zoned hit
// detection with a cooldown FSM, and the paddle pixel overlay.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int          XLOC      = 50,
  parameter int          YRESET    = 294,
  parameter int          WIDTH     = 10,
  parameter int          HEIGHT    = 60,
  parameter int          ZONES     = 3,
  parameter int          Y_MIN     = 136,
  parameter int          Y_MAX     = 512,
  parameter int          MAX_STEP  = 4,
  parameter int          BALL_SIZE = 10,
  parameter int          COOLDOWN  = 8,
  parameter logic [11:0] COLOR     = 12'hfff
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [1:0]                 mode,
  input  logic [9:0]                 pad_target,
  input  logic [9:0]                 ball_x,
  input  logic [9:0]                 ball_y,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  output logic [9:0]                 paddle_y,
  output logic                       hit,
  output logic [$clog2(ZONES)-1:0]   hit_zone,
  output logic [11:0]                rgb
);

  localparam int      ZW     = $clog2(ZONES);
  localparam int      CW     = $clog2(COOLDOWN + 1);
  localparam scoord_t X_LO   = scoord_t'(XLOC);
  localparam scoord_t X_HI   = scoord_t'(XLOC + WIDTH - 1);
  localparam scoord_t H_M1   = scoord_t'(HEIGHT - 1);
  localparam scoord_t B_M1   = scoord_t'(BALL_SIZE - 1);
  localparam scoord_t B_HALF = scoord_t'(BALL_SIZE / 2);
  localparam scoord_t H_HALF = scoord_t'(HEIGHT / 2);
  localparam scoord_t STEP   = scoord_t'(MAX_STEP);
  localparam scoord_t PY_LO  = scoord_t'(Y_MIN);
  localparam scoord_t PY_HI  = scoord_t'(Y_MAX - HEIGHT);
  localparam scoord_t PY_RST = clamp_y(scoord_t'(YRESET), PY_LO, PY_HI);

  coord_t          paddle_y_reg;
  hit_state_e      state_reg;
  logic [CW-1:0]   cool_cnt_reg;
  logic            hit_reg;
  logic [ZW-1:0]   hit_zone_reg;

  paddle_mode_e    mode_sel;
  scoord_t         py, bx, by, sx, sy;
  scoord_t         target, delta, py_next, off;
  logic            overlap;
  logic [ZW-1:0]   zone;

  assign py = scoord_t'({2'b00, paddle_y_reg});
  assign bx = scoord_t'({2'b00, ball_x});
  assign by = scoord_t'({2'b00, ball_y});
  assign sx = scoord_t'({2'b00, x});
  assign sy = scoord_t'({2'b00, y});

  always_comb begin
    case (mode)
      2'd0:    mode_sel = PLAYER;
      2'd1:    mode_sel = AI;
      default: mode_sel = HOLD;
    endcase
  end

  // AI centres the paddle on the ball centre; both sources are clamped.
  always_comb begin
    target = clamp_y((mode_sel == AI) ? (by + B_HALF - H_HALF) : scoord_t'({2'b00, pad_target}),
                     PY_LO, PY_HI);
    delta  = target - py;
    if (delta > STEP)       py_next = py + STEP;
    else if (delta < -STEP) py_next = py - STEP;
    else                    py_next = target;
  end

  assign overlap = (bx <= X_HI) && (bx + B_M1 >= X_LO) &&
                   (by <= py + H_M1) && (by + B_M1 >= py);
  assign off     = by + B_HALF - py;

  hit_zone_enc #(
    .HEIGHT (HEIGHT),
    .ZONES  (ZONES),
    .ZW     (ZW)
  ) u_zone (
    .off  (off),
    .zone (zone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_y_reg <= coord_t'(PY_RST);
      state_reg    <= IDLE;
      cool_cnt_reg <= '0;
      hit_reg      <= 1'b0;
      hit_zone_reg <= '0;
    end else begin
      hit_reg <= 1'b0;
      if (frame_tick) begin
        if (mode_sel != HOLD) paddle_y_reg <= coord_t'(py_next);
        case (state_reg)
          IDLE: begin
            if (overlap) begin
              state_reg    <= COOL;
              cool_cnt_reg <= '0;
              hit_reg      <= 1'b1;
              hit_zone_reg <= zone;
            end
          end
          COOL: begin
            if (cool_cnt_reg == CW'(COOLDOWN - 1)) begin
              state_reg    <= overlap ? WAIT_CLEAR : IDLE;
              cool_cnt_reg <= '0;
            end else begin
              cool_cnt_reg <= cool_cnt_reg + 1'b1;
            end
          end
          WAIT_CLEAR: begin
            if (!overlap) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign paddle_y = paddle_y_reg;
  assign hit      = hit_reg;
  assign hit_zone = hit_zone_reg;
  assign rgb      = (sx >= X_LO && sx <= X_HI && sy >= py && sy <= py + H_M1) ? COLOR : 12'h000;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: expected hit/zone/paddle_y are queued per
// frame_tick and compared one cycle later, plus reset and pixel checks.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [9:0]  pad_target = 10'd0;
  logic [9:0]  ball_x = 10'd600;
  logic [9:0]  ball_y = 10'd600;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic [9:0]  paddle_y;
  logic        hit;
  logic [1:0]  hit_zone;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;
  logic [1:0] last_zone = 2'd0;

  typedef struct {
    logic       h;
    logic [1:0] z;
    logic [9:0] py;
  } exp_t;

  exp_t exp_q[$];

  paddle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .mode       (mode),
    .pad_target (pad_target),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .x          (x),
    .y          (y),
    .paddle_y   (paddle_y),
    .hit        (hit),
    .hit_zone   (hit_zone),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  function automatic int step_to(input int p, input int t);
    if (t > p + 4) return p + 4;
    if (t < p - 4) return p - 4;
    return t;
  endfunction

  task automatic push_exp(input logic h, input logic [1:0] z, input int p);
    exp_t e;
    e.h  = h;
    e.z  = z;
    e.py = 10'(p);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_zone = 2'd0;
  endtask

  task automatic test_reset();
    int tx[6] = '{50, 49, 59, 60, 55, 55};
    int ty[6] = '{294, 294, 353, 353, 293, 354};
    logic [11:0] tc[6] = '{12'hfff, 12'h000, 12'hfff, 12'h000, 12'h000, 12'h000};
    do_reset();
    checks++;
    if (paddle_y !== 10'd294 || hit !== 1'b0 || hit_zone !== 2'd0) begin
      errors++;
      $display("FAIL reset: py=%0d hit=%b zone=%0d required py=294 hit=0 zone=0", paddle_y, hit, hit_zone);
    end
    $display("reset: py=%0d hit=%b zone=%0d", paddle_y, hit, hit_zone);
    for (int i = 0; i < 6; i++) begin
      x = 10'(tx[i]);
      y = 10'(ty[i]);
      #1;
      checks++;
      if (rgb !== tc[i]) begin
        errors++;
        $display("FAIL rgb x=%0d y=%0d: got %h required %h", x, y, rgb, tc[i]);
      end
      $display("rgb x=%0d y=%0d: %h", x, y, rgb);
    end
  endtask

  task automatic test_player_motion();
    int tin[3] = '{400, 600, 0};
    int tcl[3] = '{400, 452, 136};
    int n[3]   = '{30, 20, 85};
    int p = 294;
    exp_t e;
    mode = 2'd0;
    for (int s = 0; s < 3; s++) begin
      pad_target = 10'(tin[s]);
      for (int k = 0; k < n[s]; k++) begin
        p = step_to(p, tcl[s]);
        push_exp(1'b0, last_zone, p);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
          errors++;
          $display("FAIL player t=%0d k=%0d: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                   tin[s], k, hit, hit_zone, paddle_y, e.h, e.z, e.py);
        end
        $display("player t=%0d k=%0d: py=%0d", tin[s], k, paddle_y);
      end
    end
  endtask

  task automatic test_zones();
    int tbx[14] = '{55, 55, 55, 55, 55, 55, 55, 55, 55, 55, 55, 41, 40, 59};
    int tby[14] = '{300, 330, 286, 308, 309, 328, 329, 353, 354, 284, 285, 300, 300, 300};
    logic th[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
    logic [1:0] tz[14] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_t e;
    do_reset();
    mode = 2'd0;
    pad_target = 10'd294;
    for (int i = 0; i < 14; i++) begin
      ball_x = 10'(tbx[i]);
      ball_y = 10'(tby[i]);
      if (th[i]) last_zone = tz[i];
      push_exp(th[i], last_zone, 294);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
        errors++;
        $display("FAIL zone bx=%0d by=%0d: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                 tbx[i], tby[i], hit, hit_zone, paddle_y, e.h, e.z, e.py);
      end
      $display("zone bx=%0d by=%0d: hit=%b zone=%0d", tbx[i], tby[i], hit, hit_zone);
      @(posedge clk);
      #1;
      checks++;
      if (hit !== 1'b0) begin
        errors++;
        $display("FAIL hit_width bx=%0d by=%0d: hit=%b required 0", tbx[i], tby[i], hit);
      end
      ball_x = 10'd600;
      for (int k = 0; k < 10; k++) begin
        push_exp(1'b0, last_zone, 294);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
          errors++;
          $display("FAIL zone_clear i=%0d k=%0d: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                   i, k, hit, hit_zone, paddle_y, e.h, e.z, e.py);
        end
      end
    end
  endtask

  task automatic test_cooldown();
    logic sp[$];
    logic sh[$];
    exp_t e;
    for (int i = 0; i < 20; i++) begin sp.push_back(1'b1); sh.push_back(i == 0); end
    sp.push_back(1'b0); sh.push_back(1'b0);
    sp.push_back(1'b1); sh.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin sp.push_back(1'b0); sh.push_back(1'b0); end
    for (int i = 0; i < 6; i++) begin sp.push_back(1'b1); sh.push_back(1'b0); end
    sp.push_back(1'b0); sh.push_back(1'b0);
    sp.push_back(1'b1); sh.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin sp.push_back(1'b0); sh.push_back(1'b0); end
    sp.push_back(1'b1); sh.push_back(1'b1);
    for (int i = 0; i < 7; i++) begin sp.push_back(1'b0); sh.push_back(1'b0); end
    sp.push_back(1'b1); sh.push_back(1'b0);
    sp.push_back(1'b1); sh.push_back(1'b0);
    sp.push_back(1'b0); sh.push_back(1'b0);
    sp.push_back(1'b1); sh.push_back(1'b1);
    for (int i = 0; i < 10; i++) begin sp.push_back(1'b0); sh.push_back(1'b0); end
    mode = 2'd0;
    pad_target = 10'd294;
    ball_y = 10'd330;
    for (int i = 0; i < sp.size(); i++) begin
      ball_x = sp[i] ? 10'd55 : 10'd600;
      if (sh[i]) last_zone = 2'd2;
      push_exp(sh[i], last_zone, 294);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
        errors++;
        $display("FAIL cooldown step=%0d present=%b: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                 i, sp[i], hit, hit_zone, paddle_y, e.h, e.z, e.py);
      end
      $display("cooldown step=%0d present=%b: hit=%b", i, sp[i], hit);
    end
  endtask

  task automatic test_ai_hold();
    int p = 294;
    int seg_mode[4] = '{1, 2, 3, 1};
    int seg_n[4]    = '{10, 6, 3, 25};
    exp_t e;
    logic h;
    do_reset();
    ball_x = 10'd600;
    ball_y = 10'd200;
    for (int s = 0; s < 4; s++) begin
      mode = 2'(seg_mode[s]);
      for (int k = 0; k < seg_n[s]; k++) begin
        h = 1'b0;
        if (s == 1 && k == 5) begin
          ball_x = 10'd55;
          ball_y = 10'd260;
          h = 1'b1;
          last_zone = 2'd0;
        end else begin
          ball_x = 10'd600;
          ball_y = 10'd200;
        end
        if (seg_mode[s] == 1) p = step_to(p, 175);
        push_exp(h, last_zone, p);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
          errors++;
          $display("FAIL ai_hold mode=%0d k=%0d: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                   seg_mode[s], k, hit, hit_zone, paddle_y, e.h, e.z, e.py);
        end
        $display("ai_hold mode=%0d k=%0d: py=%0d hit=%b", seg_mode[s], k, paddle_y, hit);
      end
    end
  endtask

  task automatic test_reset_mid_cool();
    logic sh[4] = '{1, 0, 0, 1};
    exp_t e;
    do_reset();
    mode = 2'd0;
    pad_target = 10'd294;
    ball_x = 10'd55;
    ball_y = 10'd330;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_zone = 2'd0;
        checks++;
        if (paddle_y !== 10'd294 || hit !== 1'b0 || hit_zone !== 2'd0) begin
          errors++;
          $display("FAIL mid_cool_reset: py=%0d hit=%b zone=%0d required py=294 hit=0 zone=0",
                   paddle_y, hit, hit_zone);
        end
        $display("mid_cool_reset: py=%0d hit=%b zone=%0d", paddle_y, hit, hit_zone);
      end
      if (sh[i]) last_zone = 2'd2;
      push_exp(sh[i], last_zone, 294);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (hit !== e.h || hit_zone !== e.z || paddle_y !== e.py) begin
        errors++;
        $display("FAIL mid_cool step=%0d: hit=%b zone=%0d py=%0d required hit=%b zone=%0d py=%0d",
                 i, hit, hit_zone, paddle_y, e.h, e.z, e.py);
      end
      $display("mid_cool step=%0d: hit=%b zone=%0d", i, hit, hit_zone);
    end
  endtask

  initial begin
    test_reset();
    test_player_motion();
    test_zones();
    test_cooldown();
    test_ai_hold();
    test_reset_mid_cool();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
